// File: rtl/sha_uart_pkg.sv
// Shared constants for the SHA-256 -> UART reporting path.
//   DIGEST_W  : width of a SHA-256 digest in bits
//   HEX_CHARS : number of hex characters needed to print one digest
//   ASCII_CR / ASCII_LF : line terminator bytes appended after the hex text
package sha_uart_pkg;

    localparam int DIGEST_W  = 256;
    localparam int HEX_CHARS = 64;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to ASCII hex digit converter.
//   nibble    : 4-bit value 0..15
//   uppercase : 1 selects 'A'-'F', 0 selects 'a'-'f' for values 10..15
//   ascii     : ASCII code of the hex digit
module nibble_to_ascii (
    input  logic [3:0] nibble,
    input  logic       uppercase,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = (uppercase ? 8'h41 : 8'h61) + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/digest_hex_tx.sv
// Prints a SHA-256 digest as ASCII hex over a byte-wide UART transmitter,
// optionally followed by CR LF.
//   clk, rst       : clock, asynchronous active-high reset
//   digest_valid   : hash core offers a digest (accepted only in IDLE)
//   digest         : digest, bits [255:252] are printed first
//   digest_ready   : high only while idle and able to latch a digest
//   tx_start       : one-cycle send request to the UART
//   tx_data        : byte to send, held between requests, 0x00 after reset
//   tx_busy        : UART busy flag, rises the cycle after tx_start
//   busy           : a frame is in progress
//   done           : one-cycle pulse after the last byte has left the UART
module digest_hex_tx
    import sha_uart_pkg::*;
#(
    parameter bit APPEND_CRLF = 1'b1,
    parameter bit UPPERCASE   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                digest_valid,
    input  logic [DIGEST_W-1:0] digest,
    output logic                digest_ready,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_FREE,
        FINISH
    } state_t;

    localparam logic [6:0] FRAME_LEN = APPEND_CRLF ? 7'd66 : 7'd64;
    localparam logic [6:0] HEX_LEN   = 7'(HEX_CHARS);

    state_t              state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;

    logic [7:0]          hex_ascii;
    logic [7:0]          cur_char;
    logic                issue_fire;
    logic                char_done;

    nibble_to_ascii u_nibble_to_ascii (
        .nibble    (shreg_q[DIGEST_W-1 -: 4]),
        .uppercase (UPPERCASE),
        .ascii     (hex_ascii)
    );

    // The top nibble of the shift register is always the next hex char;
    // once the hex text is exhausted the counter selects CR then LF.
    always_comb begin
        if (cnt_q < HEX_LEN) begin
            cur_char = hex_ascii;
        end else if (cnt_q == HEX_LEN) begin
            cur_char = ASCII_CR;
        end else begin
            cur_char = ASCII_LF;
        end
    end

    assign issue_fire = (state_q == ISSUE) && !tx_busy;
    assign char_done  = (state_q == WAIT_FREE) && !tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (digest_valid) state_d = ISSUE;
            ISSUE:     if (!tx_busy) state_d = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) state_d = WAIT_FREE;
            WAIT_FREE: if (!tx_busy) state_d = ((cnt_q + 7'd1) < FRAME_LEN) ? ISSUE : FINISH;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        digest_ready = (state_q == IDLE);
        busy         = (state_q != IDLE);
        done         = (state_q == FINISH);
        tx_start     = tx_start_q;
        tx_data      = tx_data_q;
    end

    // tx_start and tx_data are registered together so the byte is stable
    // for the whole cycle the UART samples the request.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if ((state_q == IDLE) && digest_valid) begin
            shreg_d = digest;
            cnt_d   = 7'd0;
        end
        if (issue_fire) begin
            tx_start_d = 1'b1;
            tx_data_d  = cur_char;
            if (cnt_q < HEX_LEN) begin
                shreg_d = {shreg_q[DIGEST_W-5:0], 4'h0};
            end
        end
        if (char_done) begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            cnt_q      <= 7'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_digest_hex_tx.sv
// Testbench for digest_hex_tx: two instances (defaults, and uppercase
// without CR LF) driven against a UART model with random byte times.
module tb_digest_hex_tx;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         dv;
    logic [1:0][255:0]  dg;
    logic [1:0]         dr;
    logic [1:0]         ts;
    logic [1:0][7:0]    td;
    logic [1:0]         tb_busy;
    logic [1:0]         by;
    logic [1:0]         dn;

    int checks = 0;
    int errors = 0;

    // UART model / monitor state
    int ub [2];
    int ucnt [2];
    int starts [2];
    int dones [2];
    int done_len [2];
    int done_ub [2];
    int ready_bad [2];
    int proto_bad [2];
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];
    bit stall_req, stall_arm, stall_on, stall_done;
    int stall_after, stall_cnt, stall_bad;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] SEQ_DIGEST =
        256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

    digest_hex_tx u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .digest_valid (dv[0]),
        .digest       (dg[0]),
        .digest_ready (dr[0]),
        .tx_start     (ts[0]),
        .tx_data      (td[0]),
        .tx_busy      (tb_busy[0]),
        .busy         (by[0]),
        .done         (dn[0])
    );

    digest_hex_tx #(.APPEND_CRLF(1'b0), .UPPERCASE(1'b1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .digest_valid (dv[1]),
        .digest       (dg[1]),
        .digest_ready (dr[1]),
        .tx_start     (ts[1]),
        .tx_data      (td[1]),
        .tx_busy      (tb_busy[1]),
        .busy         (by[1]),
        .done         (dn[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: text the instance should print for digest d, position i.
    function automatic logic [7:0] exp_char(input int k, input logic [255:0] d, input int i);
        logic [3:0] n;
        int letter_base;
        letter_base = (k == 1) ? 65 : 97;
        if (i < 64) begin
            n = d[255 - 4*i -: 4];
            if (n < 10) return 8'(48 + int'(n));
            return 8'(letter_base + int'(n) - 10);
        end
        return (i == 64) ? 8'h0D : 8'h0A;
    endfunction

    function automatic int flen(input int k);
        return (k == 0) ? 66 : 64;
    endfunction

    function automatic int rxsize(input int k);
        return (k == 0) ? rx0.size() : rx1.size();
    endfunction

    function automatic logic [7:0] rxbyte(input int k, input int i);
        return (k == 0) ? rx0[i] : rx1[i];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // UART model: accepts a byte on tx_start, stays busy 1..5 cycles.
    initial begin
        bit dropped;
        for (int k = 0; k < 2; k++) begin
            ub[k] = 0; ucnt[k] = 0; starts[k] = 0; dones[k] = 0;
            done_len[k] = 0; done_ub[k] = 0; ready_bad[k] = 0; proto_bad[k] = 0;
        end
        stall_arm = 0; stall_on = 0; stall_cnt = 0; stall_bad = 0;
        tb_busy = 2'b00;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                dropped = 0;
                if (ts[k]) begin
                    starts[k]++;
                    if (ub[k] != 0) proto_bad[k]++;
                    if (k == 0) rx0.push_back(td[k]);
                    else        rx1.push_back(td[k]);
                    ub[k]   = 1;
                    ucnt[k] = $urandom_range(1, 5);
                end else if (ub[k] != 0) begin
                    ucnt[k]--;
                    if (ucnt[k] == 0) begin
                        ub[k]   = 0;
                        dropped = 1;
                    end
                end
                if (dn[k]) begin
                    dones[k]++;
                    done_len[k] = rxsize(k);
                    done_ub[k]  = ub[k];
                end
                if (dr[k] == by[k]) ready_bad[k]++;
                if (k == 0) begin
                    if (stall_on) begin
                        if (ts[0]) stall_bad++;
                        stall_cnt--;
                        if (stall_cnt == 0) begin
                            stall_on   = 0;
                            stall_done = 1;
                        end
                    end else if (stall_arm) begin
                        stall_arm = 0;
                        stall_on  = 1;
                        stall_cnt = 100;
                    end else if (dropped && stall_req && rx0.size() == stall_after) begin
                        stall_req = 0;
                        stall_arm = 1;
                    end
                end
                tb_busy[k] = (ub[k] != 0) || (k == 0 && stall_on);
            end
        end
    end

    task automatic offer(input int k, input logic [255:0] d, output logic acc);
        dv[k] = 1'b1;
        dg[k] = d;
        acc   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (dr[k]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        dv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int base, input string tag);
        for (int c = 0; c < 5000; c++) begin
            if (dones[k] > base) break;
            @(negedge clk);
        end
        chk(tag, 64'(dones[k] > base), 64'd1);
    endtask

    task automatic compare_frames(input int k, input logic [255:0] d, input int base,
                                  input int nframes, input string tag);
        int len, mism;
        len  = rxsize(k) - base;
        mism = 0;
        chk({tag, "_len"}, 64'(len), 64'(flen(k) * nframes));
        for (int i = 0; i < len && i < flen(k) * nframes; i++) begin
            if (rxbyte(k, base + i) !== exp_char(k, d, i % flen(k))) mism++;
        end
        chk({tag, "_bytes_bad"}, 64'(mism), 64'd0);
    endtask

    task automatic run_frame(input int k, input logic [255:0] d, input string tag);
        int base_rx, base_st, base_dn;
        logic acc;
        base_rx = rxsize(k);
        base_st = starts[k];
        base_dn = dones[k];
        offer(k, d, acc);
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        wait_done(k, base_dn, {tag, "_done_seen"});
        repeat (2) @(negedge clk);
        compare_frames(k, d, base_rx, 1, tag);
        chk({tag, "_starts"}, 64'(starts[k] - base_st), 64'(flen(k)));
        chk({tag, "_dones"}, 64'(dones[k] - base_dn), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [255:0] d, latched;
        int base_rx, base_dn, cyc, rdy_hi;

        rst = 1'b1;
        dv  = 2'b00;
        dg  = '0;
        stall_req = 0; stall_done = 0; stall_after = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(dr[0]), 64'd1);
        chk("rst_busy", 64'(by[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_tx_start", 64'(ts[0]), 64'd0);
        chk("rst_tx_data", 64'(td[0]), 64'h00);
        chk("rst_ready1", 64'(dr[1]), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "abc" digest with both parameter sets
        run_frame(0, ABC_DIGEST, "abc_lc_crlf");
        run_frame(1, ABC_DIGEST, "abc_uc_nocrlf");
        chk("uc_done_after_byte64", 64'(done_len[1]), 64'd64);
        chk("uc_done_uart_idle", 64'(done_ub[1]), 64'd0);

        // back-to-back: second digest offered while done is high
        base_rx = rx0.size();
        base_dn = dones[0];
        offer(0, SEQ_DIGEST, acc);
        chk("b2b_accept1", 64'(acc), 64'd1);
        for (cyc = 0; cyc < 5000 && !dn[0]; cyc++) @(negedge clk);
        chk("b2b_done1_seen", 64'(dn[0]), 64'd1);
        dv[0] = 1'b1;
        dg[0] = SEQ_DIGEST;
        @(negedge clk);
        chk("b2b_ready_after_done", 64'(dr[0]), 64'd1);
        @(negedge clk);
        dv[0] = 1'b0;
        chk("b2b_accept2_busy", 64'(by[0]), 64'd1);
        wait_done(0, base_dn + 1, "b2b_done2_seen");
        repeat (2) @(negedge clk);
        compare_frames(0, SEQ_DIGEST, base_rx, 2, "b2b");

        // digest_valid held high with a changing digest during a frame
        base_rx = rx0.size();
        base_dn = dones[0];
        rdy_hi  = 0;
        dv[0]   = 1'b1;
        dg[0]   = rand256();
        for (cyc = 0; cyc < 200 && !dr[0]; cyc++) begin
            @(negedge clk);
            dg[0] = rand256();
        end
        latched = dg[0];
        @(negedge clk);
        for (cyc = 0; cyc < 5000 && !dn[0]; cyc++) begin
            dg[0] = rand256();
            if (dr[0]) rdy_hi++;
            @(negedge clk);
        end
        dv[0] = 1'b0;
        chk("hold_done_seen", 64'(dn[0]), 64'd1);
        chk("hold_ready_low", 64'(rdy_hi), 64'd0);
        repeat (2) @(negedge clk);
        compare_frames(0, latched, base_rx, 1, "hold");
        chk("hold_dones", 64'(dones[0] - base_dn), 64'd1);

        // reset after byte 10 aborts the frame
        base_rx = rx0.size();
        d = rand256();
        offer(0, d, acc);
        for (cyc = 0; cyc < 2000 && rx0.size() < base_rx + 10; cyc++) @(negedge clk);
        chk("rstmid_reached10", 64'(rx0.size() >= base_rx + 10), 64'd1);
        base_dn = dones[0];
        rst = 1'b1;
        #1;
        chk("rstmid_tx_start", 64'(ts[0]), 64'd0);
        chk("rstmid_busy", 64'(by[0]), 64'd0);
        chk("rstmid_ready", 64'(dr[0]), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("rstmid_no_done", 64'(dones[0] - base_dn), 64'd0);
        run_frame(0, rand256(), "after_rst");

        // tx_busy held high for 100 cycles while a char is pending
        stall_done  = 0;
        stall_bad   = 0;
        stall_after = rx0.size() + 5;
        stall_req   = 1;
        run_frame(0, rand256(), "stall");
        chk("stall_happened", 64'(stall_done), 64'd1);
        chk("stall_no_tx_start", 64'(stall_bad), 64'd0);

        // random frames on both instances
        for (int r = 0; r < 4; r++) run_frame(r % 2, rand256(), "rand");

        chk("ready_vs_busy0", 64'(ready_bad[0]), 64'd0);
        chk("ready_vs_busy1", 64'(ready_bad[1]), 64'd0);
        chk("start_while_uart_busy0", 64'(proto_bad[0]), 64'd0);
        chk("start_while_uart_busy1", 64'(proto_bad[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digest_hex_tx.md
DIGEST_HEX_TX -- requirements
Module: digest_hex_tx

Interface
REQ-001 Parameter APPEND_CRLF, default 1: when 1, append CR (0x0D) and LF (0x0A) after the 64 hex characters.
REQ-002 Parameter UPPERCASE, default 0: when 1, hex letters are 'A'-'F' (0x41-0x46); otherwise 'a'-'f' (0x61-0x66).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 digest_valid  input  1  digest offered by the hash core.
REQ-006 digest  input  256  SHA-256 digest; bits [255:252] are the first nibble sent.
REQ-007 digest_ready  output  1  block can accept a digest.
REQ-008 tx_start  output  1  one-cycle request to the UART transmitter.
REQ-009 tx_data  output  8  ASCII byte for the UART; valid while tx_start is high.
REQ-010 tx_busy  input  1  UART transmitter busy flag.
REQ-011 busy  output  1  frame in progress.
REQ-012 done  output  1  one-cycle pulse when the last byte of a frame has finished on the UART.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK, WAIT_FREE and FINISH.
REQ-014 In IDLE: digest_ready=1 and busy=0; when digest_valid=1, latch digest into a 256-bit shift register, clear the char counter, go to ISSUE.
REQ-015 digest_ready SHALL be 0 in every state except IDLE; digest_valid outside IDLE is ignored and does not alter the latched digest.
REQ-016 In ISSUE with tx_busy=0: assert tx_start for exactly one cycle with tx_data = current char, then go to WAIT_ACK. With tx_busy=1: hold in ISSUE, no tx_start.
REQ-017 In WAIT_ACK: stay until tx_busy=1, then go to WAIT_FREE; tx_start stays 0 (tx_busy rises one cycle after tx_start).
REQ-018 In WAIT_FREE: stay until tx_busy=0; then increment the char counter and go to ISSUE if chars remain, else FINISH.
REQ-019 Char order: 64 hex chars, most significant nibble first; after each hex char the shift register shifts left by 4 bits.
REQ-020 Frame length SHALL be 66 chars when APPEND_CRLF=1 and 64 when APPEND_CRLF=0; the char counter is 7 bits and never wraps within a frame.
REQ-021 Nibble-to-ASCII: 0-9 -> 0x30-0x39; 10-15 -> letter base per UPPERCASE.
REQ-022 FINISH: assert done for one cycle, then return to IDLE; digest_ready rises on the cycle after done.
REQ-023 busy=1 in every state except IDLE.
REQ-024 tx_data SHALL hold its last value when tx_start=0 and be 0x00 after reset.
REQ-025 Back-to-back frames: the minimum gap is done cycle + one IDLE accept cycle; no byte is dropped or duplicated.

Reset
REQ-026 On rst=1, asynchronously force IDLE, digest_ready=1, busy=0, done=0, tx_start=0, tx_data=0x00, counter=0 and shift register=0.
REQ-027 Reset mid-frame aborts the frame; no done pulse; the next frame after reset starts at char 0.

Structure
REQ-028 Shared package sha_uart_pkg holds DIGEST_W=256, HEX_CHARS=64, ASCII_CR=0x0D and ASCII_LF=0x0A; the FSM state enum is local to the block.
REQ-029 One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out, uppercase select), is instantiated once.
REQ-030 The block connects directly to the existing UART tx_start/tx_data/tx_busy port set with no glue logic.

Verification
REQ-031 Digest of "abc" (ba7816bf...f20015ad), defaults -> UART model decodes "ba7816bf...f20015ad" then 0x0D 0x0A; done pulses once; 66 tx_start pulses.
REQ-032 Same digest, UPPERCASE=1, APPEND_CRLF=0 -> "BA7816BF...F20015AD"; exactly 64 bytes; done after byte 64 completes.
REQ-033 Digest 0x0123...CDEF repeated, second digest offered on the cycle done is high -> second frame accepted on the next IDLE cycle; both frames are byte-exact with no loss.
REQ-034 digest_valid held high with a changing digest during a frame -> the frame matches the digest latched at accept; digest_ready=0 throughout.
REQ-035 rst asserted after byte 10 -> tx_start=0 immediately, no done pulse; a new digest after reset is transmitted from char 0.
REQ-036 tx_busy held high by the bench for 100 cycles in ISSUE -> no tx_start issued until tx_busy falls; exactly one tx_start per char.
